udp_tx_axis_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single 512-bit UDP TX AXI-Stream input of the UDP/CMAC datapath between NUM_PORTS requesters, e.g. XDMA H2C and the perf-monitor packet generator.
Once a port is granted, it holds the output until its tlast beat is accepted, so packets are never interleaved.
The output is registered through a 2-entry skid buffer, which breaks cross-die timing paths.
The block sits on the XDMA clock domain, in front of the TX buffer that feeds the UDP/CMAC wrapper.

---
 rtl/udp_tx_axis_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_udp_tx_axis_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_axis_arbiter.sv
// udp_tx_axis_arbiter: packet-granular round-robin arbiter of NUM_PORTS AXIS sources onto one UDP TX stream.
// Latency: grant one cycle after request, first beat on m_axis two cycles after request; one idle cycle per packet.
// Backpressure: 2-entry skid buffer, granted tready drops when both entries are held. ARB_PKT_COUNT_EN adds pkt_count.
module udp_tx_axis_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic                             CLK,
  input  logic                             RST_N,
  input  logic [NUM_PORTS-1:0]             port_enable,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  output logic [2:0]                       grant_idx,
  output logic                             busy
`ifdef ARB_PKT_COUNT_EN
  ,
  output logic [NUM_PORTS*32-1:0]          pkt_count
`endif
);

  typedef enum logic {IDLE, XFER} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  state_e               state_q, state_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           last_grant_q, last_grant_d;
  logic [NUM_PORTS-1:0] req;
  logic [2:0]           winner;
  logic                 winner_vld;
  beat_t                sel_beat;
  logic                 sel_vld;
  beat_t                head_q, head_d;
  beat_t                tail_q, tail_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign req  = s_axis_tvalid & port_enable;
  assign full = (cnt_q == 2'd2);
  // tready comes from registered state/occupancy only, so push never depends on m_axis_tready
  assign push = (state_q == XFER) && !full && sel_vld;
  assign pop  = (cnt_q != 2'd0) && m_axis_tready;

  // Round-robin search: first requester above last_grant, wrapping
  always_comb begin
    winner     = last_grant_q;
    winner_vld = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!winner_vld && req[j] &&
            (((int'(last_grant_q) + k) >= NUM_PORTS ? (int'(last_grant_q) + k - NUM_PORTS)
                                                    : (int'(last_grant_q) + k)) == j)) begin
          winner     = 3'(j);
          winner_vld = 1'b1;
        end
      end
    end
  end

  // Select the granted port's beat and drive its tready
  always_comb begin
    sel_vld       = 1'b0;
    sel_beat      = '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == 3'(i)) begin
        sel_vld       = s_axis_tvalid[i];
        sel_beat.data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_beat.keep = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_beat.last = s_axis_tlast[i];
        sel_beat.user = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
        s_axis_tready[i] = (state_q == XFER) && !full;
      end
    end
  end

  // FSM next state: arbitrate in IDLE, hold the grant until the tlast beat is accepted
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (winner_vld) begin
          grant_d      = winner;
          last_grant_d = winner;
          state_d      = XFER;
        end
      end
      XFER: begin
        if (push && sel_beat.last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer next state: head feeds m_axis, tail catches the second beat
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          head_d = sel_beat;
        end else begin
          tail_d = sel_beat;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = sel_beat;
        end else begin
          head_d = tail_q;
          tail_d = sel_beat;
        end
      end
      default: ;
    endcase
  end

  // State, grant and skid registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      grant_q      <= 3'd0;
      last_grant_q <= 3'(NUM_PORTS - 1);
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= 2'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
    end
  end

  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_axis_tdata  = head_q.data;
  assign m_axis_tkeep  = head_q.keep;
  assign m_axis_tlast  = head_q.last;
  assign m_axis_tuser  = head_q.user;
  assign grant_idx     = grant_q;
  assign busy          = (state_q == XFER);

`ifdef ARB_PKT_COUNT_EN
  logic [31:0] pkt_cnt_q [NUM_PORTS];

  // Count tlast beats accepted per port; free-running wrap
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i] <= 32'd0;
      end
    end else if (push && sel_beat.last) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_q == 3'(i)) begin
          pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  // Flatten counters onto the output port
  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pkt_count[i*32 +: 32] = pkt_cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_udp_tx_axis_arbiter.sv
// tb_udp_tx_axis_arbiter: scoreboard bench for udp_tx_axis_arbiter (2 ports, 512-bit).
// Drivers push expected beats per port; a monitor pops on each m_axis handshake.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_udp_tx_axis_arbiter;
  localparam int NP = 2;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } tb_beat_t;

  logic             CLK;
  logic             RST_N;
  logic [NP-1:0]    port_enable;
  logic [NP-1:0]    s_axis_tvalid;
  logic [NP-1:0]    s_axis_tready;
  logic [NP*DW-1:0] s_axis_tdata;
  logic [NP*KW-1:0] s_axis_tkeep;
  logic [NP-1:0]    s_axis_tlast;
  logic [NP*UW-1:0] s_axis_tuser;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep;
  logic             m_axis_tlast;
  logic [UW-1:0]    m_axis_tuser;
  logic [2:0]       grant_idx;
  logic             busy;
`ifdef ARB_PKT_COUNT_EN
  logic [NP*32-1:0] pkt_count;
`endif

  udp_tx_axis_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .CLK(CLK), .RST_N(RST_N), .port_enable(port_enable),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .grant_idx(grant_idx), .busy(busy)
`ifdef ARB_PKT_COUNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  // stimulus / scoreboard state
  tb_beat_t drv_q [NP][$];
  tb_beat_t exp_q [NP][$];
  int       exp_order [$];
  int       pkt_start_q [$];
  logic     drv_vld  [NP];
  logic     acc_pend [NP];
  logic     first    [NP];
  int       acc_cnt  [NP];
  int       mdl_cnt  [NP];
  int       vld_cyc  [NP];
  int       last_acc_cyc [NP];
  int       vld_pct;
  int       rdy_pct;
  int       cyc;
  int       busy_fall_cyc;
  int       trdy1_hi;
  int       seq;
  int       n_chk;
  int       n_pass;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  // queue one packet for port p; the same beats become the expected output
  task automatic push_pkt(input int p, input int len);
    tb_beat_t b;
    for (int i = 0; i < len; i++) begin
      for (int w = 0; w < 15; w++) b.data[w*32 +: 32] = $urandom();
      b.data[DW-1 -: 32] = {8'(p), 16'(seq), 8'(i)};
      b.keep = {$urandom(), $urandom()};
      b.last = (i == len - 1);
      b.user = UW'($urandom());
      drv_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
    seq++;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    for (int p = 0; p < NP; p++) begin
      drv_q[p].delete();
      exp_q[p].delete();
      acc_cnt[p] = 0;
      mdl_cnt[p] = 0;
    end
    exp_order.delete();
    pkt_start_q.delete();
    trdy1_hi = 0;
    busy_fall_cyc = -1;
    tick(3);
    RST_N = 1'b1;
    tick(1);
  endtask

  // source drivers: hold tvalid until accepted; tready is registered-state only
  initial begin
    for (int p = 0; p < NP; p++) begin
      drv_vld[p] = 1'b0; acc_pend[p] = 1'b0; first[p] = 1'b1;
    end
    s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tlast = '0;  s_axis_tuser = '0;
    forever begin
      @(negedge CLK);
      for (int p = 0; p < NP; p++) begin
        if (!RST_N) begin
          drv_vld[p] = 1'b0; acc_pend[p] = 1'b0; first[p] = 1'b1;
          continue;
        end
        if (acc_pend[p]) begin
          if (drv_q[p].size() > 0) begin
            first[p] = drv_q[p][0].last;
            void'(drv_q[p].pop_front());
          end
          acc_pend[p] = 1'b0;
          drv_vld[p]  = 1'b0;
        end
        if (!drv_vld[p] && drv_q[p].size() > 0 && $urandom_range(99) < vld_pct) begin
          drv_vld[p] = 1'b1;
          if (first[p]) vld_cyc[p] = cyc;
        end
        if (drv_vld[p] && s_axis_tready[p]) begin
          acc_pend[p] = 1'b1;
          acc_cnt[p]++;
          if (drv_q[p][0].last) begin
            last_acc_cyc[p] = cyc;
            mdl_cnt[p]++;
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        s_axis_tvalid[p] = drv_vld[p];
        if (drv_vld[p] && drv_q[p].size() > 0) begin
          s_axis_tdata[p*DW +: DW] = drv_q[p][0].data;
          s_axis_tkeep[p*KW +: KW] = drv_q[p][0].keep;
          s_axis_tlast[p]          = drv_q[p][0].last;
          s_axis_tuser[p*UW +: UW] = drv_q[p][0].user;
        end else begin
          s_axis_tdata[p*DW +: DW] = '0;
          s_axis_tkeep[p*KW +: KW] = '0;
          s_axis_tlast[p]          = 1'b0;
          s_axis_tuser[p*UW +: UW] = '0;
        end
      end
    end
  end

  // output monitor: drives m_axis_tready and checks every handshake against the scoreboard
  initial begin
    tb_beat_t act;
    int  tag;
    int  cur;
    logic in_pkt;
    logic busy_prev;
    in_pkt = 1'b0; busy_prev = 1'b0; cur = 0;
    m_axis_tready = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        in_pkt = 1'b0; busy_prev = 1'b0;
        continue;
      end
      if (busy_prev && !busy) busy_fall_cyc = cyc;
      busy_prev = busy;
      if (s_axis_tready[1]) trdy1_hi++;
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      if (m_axis_tvalid && m_axis_tready) begin
        act = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        tag = int'(m_axis_tdata[DW-1 -: 8]);
        if (!in_pkt) begin
          pkt_start_q.push_back(cyc);
          if (exp_order.size() > 0) chk("arb_order", 640'(tag), 640'(exp_order.pop_front()));
          cur = tag;
          in_pkt = 1'b1;
        end else begin
          chk("no_interleave", 640'(tag), 640'(cur));
        end
        if (tag < NP && exp_q[tag].size() > 0) begin
          chk("beat", 640'(act), 640'(exp_q[tag].pop_front()));
        end else begin
          n_chk++;
          $display("FAIL orphan_beat: got port tag %0d with no expected beat queued", tag);
        end
        if (m_axis_tlast) in_pkt = 1'b0;
      end
    end
  end

  initial begin
    n_chk = 0; n_pass = 0; seq = 0;
    vld_pct = 100; rdy_pct = 100;
    port_enable = '1;
    RST_N = 1'b0;
    busy_fall_cyc = -1;
    tick(3);
    // reset state
    chk("rst_ctrl", 640'({s_axis_tready, m_axis_tvalid, m_axis_tlast, grant_idx, busy}), 640'(0));
    chk("rst_data", 640'({m_axis_tdata, m_axis_tkeep, m_axis_tuser}), 640'(0));
`ifdef ARB_PKT_COUNT_EN
    chk("rst_pkt_count", 640'(pkt_count), 640'(0));
`endif
    RST_N = 1'b1;
    tick(1);

    // single 4-beat packet on port 0
    do_reset();
    push_pkt(0, 4);
    tick(2);
    chk("t1_busy", 640'(busy), 640'(1));
    chk("t1_grant", 640'(grant_idx), 640'(0));
    tick(12);
    chk("t1_drain", 640'(exp_q[0].size()), 640'(0));
    chk("t1_first_latency", 640'(pkt_start_q.size() > 0 ? pkt_start_q[0] - vld_cyc[0] : -1), 640'(2));
    chk("t1_busy_fall", 640'(busy_fall_cyc - last_acc_cyc[0]), 640'(1));
    chk("t1_port1_tready", 640'(trdy1_hi), 640'(0));

    // round robin, both ports continuously offering 3-beat packets
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_pkt(0, 3); push_pkt(1, 3);
      exp_order.push_back(0); exp_order.push_back(1);
    end
    tick(40);
    chk("rr_drain0", 640'(exp_q[0].size()), 640'(0));
    chk("rr_drain1", 640'(exp_q[1].size()), 640'(0));
    chk("rr_npkts", 640'(pkt_start_q.size()), 640'(6));
    for (int i = 1; i < pkt_start_q.size(); i++)
      chk("rr_spacing", 640'(pkt_start_q[i] - pkt_start_q[i-1]), 640'(4));

    // backpressure on an 8-beat packet
    do_reset();
    rdy_pct = 0;
    push_pkt(0, 8);
    tick(20);
    chk("bp_accepted", 640'(acc_cnt[0]), 640'(2));
    chk("bp_tready", 640'(s_axis_tready), 640'(0));
    chk("bp_mvalid", 640'(m_axis_tvalid), 640'(1));
    rdy_pct = 100;
    tick(20);
    chk("bp_accepted_all", 640'(acc_cnt[0]), 640'(8));
    chk("bp_drain", 640'(exp_q[0].size()), 640'(0));

    // enable mask, then drop enable mid-packet
    do_reset();
    port_enable = 2'b10;
    push_pkt(0, 4); push_pkt(1, 8);
    exp_order.push_back(1);
    tick(4);
    chk("en_busy", 640'(busy), 640'(1));
    chk("en_grant", 640'(grant_idx), 640'(1));
    port_enable = 2'b00;
    tick(20);
    chk("en_p1_done", 640'(exp_q[1].size()), 640'(0));
    chk("en_p0_blocked", 640'(acc_cnt[0]), 640'(0));
    chk("en_idle", 640'(busy), 640'(0));
    port_enable = 2'b01;
    exp_order.push_back(0);
    tick(15);
    chk("en_p0_done", 640'(exp_q[0].size()), 640'(0));
    port_enable = '1;

    // reset asserted during beat 3 of 5
    do_reset();
    push_pkt(0, 5);
    for (int i = 0; i < 20 && acc_cnt[0] < 3; i++) tick(1);
    chk("mr_reached_beat3", 640'(acc_cnt[0] >= 3), 640'(1));
    chk("mr_mvalid_before", 640'(m_axis_tvalid), 640'(1));
    RST_N = 1'b0;
    #1;
    chk("mr_ctrl", 640'({s_axis_tready, m_axis_tvalid, m_axis_tlast, grant_idx, busy}), 640'(0));
    chk("mr_data", 640'({m_axis_tdata, m_axis_tkeep, m_axis_tuser}), 640'(0));
    do_reset();
    push_pkt(1, 2); push_pkt(0, 2);
    exp_order.push_back(0); exp_order.push_back(1);
    tick(15);
    chk("mr_drain0", 640'(exp_q[0].size()), 640'(0));
    chk("mr_drain1", 640'(exp_q[1].size()), 640'(0));

    // randomized traffic with random enables and backpressure
    do_reset();
    vld_pct = 60; rdy_pct = 70;
    for (int k = 0; k < 15; k++) begin
      push_pkt(0, $urandom_range(6, 1));
      push_pkt(1, $urandom_range(6, 1));
    end
    for (int i = 0; i < 3000; i++) begin
      if (i < 1500 && (i % 7) == 0) port_enable = NP'($urandom());
      if (i == 1500) port_enable = '1;
      tick(1);
      if (i > 1500 && exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
    end
    port_enable = '1;
    chk("rand_drain0", 640'(exp_q[0].size()), 640'(0));
    chk("rand_drain1", 640'(exp_q[1].size()), 640'(0));

`ifdef ARB_PKT_COUNT_EN
    // per-port packet counters
    do_reset();
    vld_pct = 100; rdy_pct = 100;
    for (int k = 0; k < 5; k++) push_pkt(0, $urandom_range(3, 1));
    for (int k = 0; k < 3; k++) push_pkt(1, $urandom_range(3, 1));
    tick(60);
    chk("cnt_model", 640'(pkt_count), 640'({32'(mdl_cnt[1]), 32'(mdl_cnt[0])}));
    chk("cnt_value", 640'(pkt_count), 640'({32'd3, 32'd5}));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
